// File: rtl/load_store_unit.sv
// load_store_unit: RV32I load/store unit, one request in flight, in front of a one-cycle-latency word RAM.
// Optional build macro LSU_MISALIGN_CHECK_EN rejects misaligned or illegal-funct3 requests with rsp_err_o.
module load_store_unit #(
    parameter int ADDR_W = 8
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic              req_we_i,
    input  logic [2:0]        req_funct3_i,
    input  logic [31:0]       req_addr_i,
    input  logic [31:0]       req_wdata_i,
    output logic              rsp_valid_o,
    input  logic              rsp_ready_i,
    output logic [31:0]       rsp_rdata_o,
    output logic              rsp_err_o,
    output logic              mem_en_o,
    output logic              mem_we_o,
    output logic [3:0]        mem_be_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [31:0]       mem_wdata_o,
    input  logic [31:0]       mem_rdata_i,
    output logic [1:0]        state_o
);

    // Handshakes: a transfer happens on a rising edge where valid and ready are both 1;
    // the producer holds valid and payload stable until then, ready never depends on valid.
    typedef enum logic [1:0] {IDLE, ACCESS, LOAD, RESP} state_e;
    typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W} size_e;

    // Store funct3 1xx is illegal, so only loads use bit 2 (unsigned) with byte/half sizes.
    function automatic size_e size_of(input logic we, input logic [2:0] f3);
        if (f3[1:0] == 2'b00 && !(we && f3[2])) return SZ_B;
        if (f3[1:0] == 2'b01 && !(we && f3[2])) return SZ_H;
        return SZ_W;
    endfunction

    state_e            state_q, state_d;
    logic              we_q, we_d;
    logic [2:0]        f3_q, f3_d;
    logic [ADDR_W+1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [31:0]       rdata_q, rdata_d;
    logic              err_q, err_d;
    logic              req_err;
    size_e             size_q;
    logic [7:0]        ld_byte;
    logic [15:0]       ld_half;
    logic [31:0]       ld_data;
    logic [3:0]        st_be;
    logic [31:0]       st_wdata;
    logic              unused_addr;

    assign unused_addr = ^req_addr_i[31:ADDR_W+2];

`ifdef LSU_MISALIGN_CHECK_EN
    size_e req_size;
    logic  req_illegal;
    logic  req_misal;

    always_comb begin
        req_size    = size_of(req_we_i, req_funct3_i);
        req_illegal = req_we_i ? (req_funct3_i > 3'd2)
                               : (req_funct3_i == 3'd3 || req_funct3_i[2:1] == 2'b11);
        req_misal   = (req_size == SZ_H && req_addr_i[0]) ||
                      (req_size == SZ_W && req_addr_i[1:0] != 2'b00);
        req_err     = req_illegal || req_misal;
    end
`else
    assign req_err = 1'b0;
`endif

    assign size_q = size_of(we_q, f3_q);

    always_comb begin
        ld_byte = mem_rdata_i[{addr_q[1:0], 3'b000} +: 8];
        ld_half = addr_q[1] ? mem_rdata_i[31:16] : mem_rdata_i[15:0];
        case (size_q)
            SZ_B:    ld_data = f3_q[2] ? {24'b0, ld_byte} : {{24{ld_byte[7]}}, ld_byte};
            SZ_H:    ld_data = f3_q[2] ? {16'b0, ld_half} : {{16{ld_half[15]}}, ld_half};
            default: ld_data = mem_rdata_i;
        endcase
    end

    always_comb begin
        case (size_q)
            SZ_B: begin
                st_be    = 4'b0001 << addr_q[1:0];
                st_wdata = {4{wdata_q[7:0]}};
            end
            SZ_H: begin
                st_be    = addr_q[1] ? 4'b1100 : 4'b0011;
                st_wdata = {2{wdata_q[15:0]}};
            end
            default: begin
                st_be    = 4'b1111;
                st_wdata = wdata_q;
            end
        endcase
    end

    always_comb begin
        state_d     = state_q;
        we_d        = we_q;
        f3_d        = f3_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        rdata_d     = rdata_q;
        err_d       = err_q;
        req_ready_o = 1'b0;
        case (state_q)
            IDLE: begin
                req_ready_o = reset_i;
                if (req_valid_i && req_ready_o) begin
                    we_d    = req_we_i;
                    f3_d    = req_funct3_i;
                    addr_d  = req_addr_i[ADDR_W+1:0];
                    wdata_d = req_wdata_i;
                    rdata_d = 32'b0;
                    err_d   = req_err;
                    state_d = req_err ? RESP : ACCESS;
                end
            end
            ACCESS: state_d = we_q ? RESP : LOAD;
            LOAD: begin
                rdata_d = ld_data;
                state_d = RESP;
            end
            RESP: if (rsp_ready_i) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            state_q <= IDLE;
            we_q    <= 1'b0;
            f3_q    <= 3'b0;
            addr_q  <= '0;
            wdata_q <= 32'b0;
            rdata_q <= 32'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            f3_q    <= f3_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // RAM-side outputs are forced to zero outside ACCESS so reset clears them immediately.
    assign mem_en_o    = (state_q == ACCESS);
    assign mem_we_o    = mem_en_o && we_q;
    assign mem_be_o    = mem_en_o ? (we_q ? st_be : 4'b1111) : 4'b0000;
    assign mem_addr_o  = mem_en_o ? addr_q[ADDR_W+1:2] : '0;
    assign mem_wdata_o = mem_en_o ? st_wdata : 32'b0;
    assign rsp_valid_o = (state_q == RESP);
    assign rsp_rdata_o = rdata_q;
    assign rsp_err_o   = err_q;
    assign state_o     = state_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit; honours LSU_MISALIGN_CHECK_EN when defined.
module tb_load_store_unit;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0, req_we = 1'b0, rsp_ready = 1'b0;
  logic [2:0]  req_funct3 = 3'd0;
  logic [31:0] req_addr = 32'd0, req_wdata = 32'd0;
  logic        req_ready, rsp_valid, rsp_err, mem_en, mem_we;
  logic [31:0] rsp_rdata, mem_wdata;
  logic [3:0]  mem_be;
  logic [7:0]  mem_addr;
  logic [31:0] mem_rdata = 32'd0;
  logic [1:0]  dbg_state;

  int n_checks = 0;
  int n_fail = 0;

  // clock / reset
  always #5 clk = ~clk;

  load_store_unit #(.ADDR_W(8)) dut (
    .clk_i(clk), .reset_i(reset),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_we_i(req_we),
    .req_funct3_i(req_funct3), .req_addr_i(req_addr), .req_wdata_i(req_wdata),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_rdata_o(rsp_rdata), .rsp_err_o(rsp_err),
    .mem_en_o(mem_en), .mem_we_o(mem_we), .mem_be_o(mem_be), .mem_addr_o(mem_addr),
    .mem_wdata_o(mem_wdata), .mem_rdata_i(mem_rdata), .state_o(dbg_state)
  );

  // RAM attached to the unit plus an access monitor
  logic [31:0] ram [256] = '{default: '0};
  int          men_cnt = 0;
  logic [3:0]  last_be = 4'd0;
  logic [31:0] last_mw = 32'd0;
  logic [7:0]  last_ma = 8'd0;
  logic        last_mwe = 1'b0;

  always @(posedge clk) begin
    if (mem_en && mem_we)
      for (int i = 0; i < 4; i++)
        if (mem_be[i]) ram[mem_addr][8*i +: 8] <= mem_wdata[8*i +: 8];
    if (mem_en && !mem_we) mem_rdata <= ram[mem_addr];
    else mem_rdata <= $urandom;
    if (mem_en) begin
      men_cnt  <= men_cnt + 1;
      last_be  <= mem_be;
      last_mw  <= mem_wdata;
      last_ma  <= mem_addr;
      last_mwe <= mem_we;
    end
  end

  // reference model: byte-addressed memory and expected response of one request
  logic [7:0]  ref_mem [1024] = '{default: '0};
  logic [31:0] e_rdata, e_mw;
  logic        e_err;
  int          e_lat, e_en;
  logic [3:0]  e_be;
  logic [7:0]  e_ma;

  task automatic model_txn(input logic we, input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] wd);
    int size, off, wi;
    logic sgn;
    logic [31:0] v;
`ifdef LSU_MISALIGN_CHECK_EN
    logic illegal, misal;
`endif
    if (we) begin
      size = (f3 == 3'd0) ? 1 : (f3 == 3'd1) ? 2 : 4;
      sgn  = 1'b0;
    end else begin
      size = (f3 == 3'd0 || f3 == 3'd4) ? 1 : (f3 == 3'd1 || f3 == 3'd5) ? 2 : 4;
      sgn  = (f3 == 3'd0 || f3 == 3'd1);
    end
    off = int'(addr % 4);
    off = off - (off % size);
    wi  = int'((addr / 4) % 256);
    e_rdata = 32'd0; e_err = 1'b0; e_en = 1; e_ma = wi[7:0]; e_be = 4'd0; e_mw = 32'd0;
`ifdef LSU_MISALIGN_CHECK_EN
    illegal = we ? (f3 > 3'd2) : (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7);
    misal   = (addr % size) != 0;
    if (illegal || misal) begin
      e_err = 1'b1; e_en = 0; e_lat = 1;
      return;
    end
`endif
    if (we) begin
      e_lat = 2;
      for (int i = 0; i < size; i++) begin
        e_be[off+i] = 1'b1;
        ref_mem[wi*4+off+i] = wd[8*i +: 8];
      end
      for (int l = 0; l < 4; l++) e_mw[8*l +: 8] = wd[8*(l % size) +: 8];
    end else begin
      e_lat = 3;
      e_be  = 4'hF;
      v = 32'd0;
      for (int i = 0; i < size; i++) v[8*i +: 8] = ref_mem[wi*4+off+i];
      if (sgn && v[8*size-1])
        for (int b = 8*size; b < 32; b++) v[b] = 1'b1;
      e_rdata = v;
    end
  endtask

  // driver: one full request/response transaction, observations left in r_*
  int          r_lat, r_en;
  logic        r_to, r_err, r_mwe;
  logic [31:0] r_rdata, r_mw;
  logic [3:0]  r_be;
  logic [7:0]  r_ma;

  task automatic drive_req(input logic we, input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] wd, input int hold);
    int base, n;
    r_to = 1'b0; r_lat = 0;
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wd;
    n = 0;
    while (req_ready !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    if (req_ready !== 1'b1) begin r_to = 1'b1; req_valid = 1'b0; return; end
    base = men_cnt;
    @(negedge clk);
    req_valid = 1'b0; req_we = ~we; req_funct3 = ~f3; req_addr = $urandom; req_wdata = $urandom;
    r_lat = 1;
    while (rsp_valid !== 1'b1 && r_lat < 8) begin @(negedge clk); r_lat++; end
    if (rsp_valid !== 1'b1) begin r_to = 1'b1; return; end
    r_rdata = rsp_rdata; r_err = rsp_err; r_en = men_cnt - base;
    r_be = last_be; r_mw = last_mw; r_ma = last_ma; r_mwe = last_mwe;
    repeat (hold) @(negedge clk);
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    #2 reset = 1'b0;
    req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h64; req_wdata = 32'hFFFF_FFFF;
    repeat (3) @(negedge clk);
    n_checks++; if (req_ready !== 1'b0) begin n_fail++; $display("FAIL rst_req_ready: got %b want 0", req_ready); end
    n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL rst_rsp_valid: got %b want 0", rsp_valid); end
    n_checks++; if (rsp_rdata !== 32'd0) begin n_fail++; $display("FAIL rst_rsp_rdata: got %h want 0", rsp_rdata); end
    n_checks++; if (rsp_err !== 1'b0) begin n_fail++; $display("FAIL rst_rsp_err: got %b want 0", rsp_err); end
    n_checks++; if ({mem_en, mem_we, mem_be} !== 6'd0) begin n_fail++; $display("FAIL rst_mem_ctl: got %b want 0", {mem_en, mem_we, mem_be}); end
    n_checks++; if ({mem_addr, mem_wdata} !== 40'd0) begin n_fail++; $display("FAIL rst_mem_data: got %h want 0", {mem_addr, mem_wdata}); end
    n_checks++; if (men_cnt !== 0) begin n_fail++; $display("FAIL rst_no_access: got %0d want 0", men_cnt); end
    req_valid = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    n_checks++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL rst_release_ready: got %b want 1", req_ready); end
  endtask

  task automatic test_store_word();
    model_txn(1'b1, 3'b010, 32'h64, 32'h19);
    drive_req(1'b1, 3'b010, 32'h64, 32'h19, 0);
    n_checks++; if (r_to !== 1'b0) begin n_fail++; $display("FAIL sw_timeout: got %b want 0", r_to); end
    n_checks++; if (r_lat !== 2) begin n_fail++; $display("FAIL sw_latency: got %0d want 2", r_lat); end
    n_checks++; if (r_en !== 1) begin n_fail++; $display("FAIL sw_mem_en_cycles: got %0d want 1", r_en); end
    n_checks++; if ({r_mwe, r_be} !== 5'b11111) begin n_fail++; $display("FAIL sw_we_be: got %b want 11111", {r_mwe, r_be}); end
    n_checks++; if (r_ma !== 8'h19) begin n_fail++; $display("FAIL sw_mem_addr: got %h want 19", r_ma); end
    n_checks++; if (r_mw !== 32'h19) begin n_fail++; $display("FAIL sw_mem_wdata: got %h want 00000019", r_mw); end
    n_checks++; if ({r_err, r_rdata} !== 33'd0) begin n_fail++; $display("FAIL sw_rsp: got %h want 0", {r_err, r_rdata}); end
  endtask

  task automatic test_byte_store_merge();
    model_txn(1'b1, 3'b010, 32'h0, 32'h1122_3344);
    drive_req(1'b1, 3'b010, 32'h0, 32'h1122_3344, 0);
    n_checks++; if (r_lat !== 2) begin n_fail++; $display("FAIL preload_latency: got %0d want 2", r_lat); end
    model_txn(1'b1, 3'b000, 32'h3, 32'hAB);
    drive_req(1'b1, 3'b000, 32'h3, 32'hAB, 1);
    n_checks++; if (r_be !== 4'b1000) begin n_fail++; $display("FAIL sb_be: got %b want 1000", r_be); end
    n_checks++; if (r_mw !== 32'hABAB_ABAB) begin n_fail++; $display("FAIL sb_wdata: got %h want ababab ab", r_mw); end
    model_txn(1'b0, 3'b010, 32'h0, 32'h0);
    drive_req(1'b0, 3'b010, 32'h0, 32'h0, 0);
    n_checks++; if (r_lat !== 3) begin n_fail++; $display("FAIL lw_latency: got %0d want 3", r_lat); end
    n_checks++; if (r_rdata !== 32'hAB22_3344) begin n_fail++; $display("FAIL lw_merged: got %h want ab223344", r_rdata); end
    n_checks++; if ({r_mwe, r_be} !== 5'b01111) begin n_fail++; $display("FAIL lw_we_be: got %b want 01111", {r_mwe, r_be}); end
  endtask

  task automatic test_load_extend();
    logic [2:0]  f3s [4] = '{3'b000, 3'b100, 3'b001, 3'b101};
    logic [31:0] exp [4] = '{32'hFFFF_FFF0, 32'h0000_00F0, 32'hFFFF_80F0, 32'h0000_80F0};
    model_txn(1'b1, 3'b010, 32'h0, 32'h80F0_0000);
    drive_req(1'b1, 3'b010, 32'h0, 32'h80F0_0000, 0);
    for (int k = 0; k < 4; k++) begin
      model_txn(1'b0, f3s[k], 32'h2, 32'h0);
      drive_req(1'b0, f3s[k], 32'h2, 32'h0, k);
      n_checks++; if (r_rdata !== exp[k]) begin n_fail++; $display("FAIL load_ext f3=%b: got %h want %h", f3s[k], r_rdata, exp[k]); end
    end
  endtask

  task automatic test_misalign();
    model_txn(1'b1, 3'b010, 32'h60, 32'hCAFE_0018);
    drive_req(1'b1, 3'b010, 32'h60, 32'hCAFE_0018, 0);
    model_txn(1'b0, 3'b010, 32'h62, 32'h0);
    drive_req(1'b0, 3'b010, 32'h62, 32'h0, 0);
`ifdef LSU_MISALIGN_CHECK_EN
    n_checks++; if (r_lat !== 1) begin n_fail++; $display("FAIL misal_latency: got %0d want 1", r_lat); end
    n_checks++; if (r_en !== 0) begin n_fail++; $display("FAIL misal_no_access: got %0d want 0", r_en); end
    n_checks++; if ({r_err, r_rdata} !== {1'b1, 32'd0}) begin n_fail++; $display("FAIL misal_rsp: got %h want 100000000", {r_err, r_rdata}); end
`else
    n_checks++; if (r_lat !== 3) begin n_fail++; $display("FAIL misal_latency: got %0d want 3", r_lat); end
    n_checks++; if (r_ma !== 8'h18) begin n_fail++; $display("FAIL misal_word: got %h want 18", r_ma); end
    n_checks++; if ({r_err, r_rdata} !== {1'b0, 32'hCAFE_0018}) begin n_fail++; $display("FAIL misal_rsp: got %h want 0cafe0018", {r_err, r_rdata}); end
`endif
  endtask

  task automatic test_backpressure();
    logic [31:0] held;
    int base, n;
    model_txn(1'b1, 3'b010, 32'h10, 32'h5A5A_1234);
    drive_req(1'b1, 3'b010, 32'h10, 32'h5A5A_1234, 0);
    model_txn(1'b0, 3'b010, 32'h10, 32'h0);
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h10;
    n_checks++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL bp_idle_ready: got %b want 1", req_ready); end
    @(negedge clk);
    req_we = 1'b1; req_addr = 32'h14; req_wdata = 32'h77;
    n = 0;
    while (rsp_valid !== 1'b1 && n < 8) begin @(negedge clk); n++; end
    held = rsp_rdata;
    n_checks++; if (held !== 32'h5A5A_1234) begin n_fail++; $display("FAIL bp_rdata: got %h want 5a5a1234", held); end
    base = men_cnt;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      n_checks++; if ({rsp_valid, req_ready} !== 2'b10) begin n_fail++; $display("FAIL bp_hold_valid_ready c=%0d: got %b want 10", c, {rsp_valid, req_ready}); end
      n_checks++; if (rsp_rdata !== held) begin n_fail++; $display("FAIL bp_hold_rdata c=%0d: got %h want %h", c, rsp_rdata, held); end
    end
    n_checks++; if (men_cnt !== base) begin n_fail++; $display("FAIL bp_no_access: got %0d want %0d", men_cnt, base); end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    n_checks++; if ({rsp_valid, req_ready} !== 2'b01) begin n_fail++; $display("FAIL bp_back_idle: got %b want 01", {rsp_valid, req_ready}); end
    model_txn(1'b1, 3'b010, 32'h14, 32'h77);
    @(negedge clk);
    req_valid = 1'b0;
    n_checks++; if ({mem_en, mem_we, mem_be, mem_addr, mem_wdata} !== {2'b11, 4'hF, 8'h05, 32'h77}) begin
      n_fail++; $display("FAIL bp_second_access: got %h want %h", {mem_en, mem_we, mem_be, mem_addr, mem_wdata}, {2'b11, 4'hF, 8'h05, 32'h77});
    end
    @(negedge clk);
    n_checks++; if (rsp_valid !== 1'b1) begin n_fail++; $display("FAIL bp_second_rsp: got %b want 1", rsp_valid); end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset_mid_op();
    model_txn(1'b1, 3'b010, 32'h20, 32'h1357_2468);
    drive_req(1'b1, 3'b010, 32'h20, 32'h1357_2468, 0);
    model_txn(1'b0, 3'b010, 32'h20, 32'h0);
    drive_req(1'b0, 3'b010, 32'h20, 32'h0, 0);
    // abort a load in LOAD
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h20;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    #1;
    n_checks++; if ({rsp_valid, rsp_err, req_ready, mem_en, mem_we} !== 5'd0) begin n_fail++; $display("FAIL midrst_ctl: got %b want 0", {rsp_valid, rsp_err, req_ready, mem_en, mem_we}); end
    n_checks++; if ({rsp_rdata, mem_be, mem_addr, mem_wdata} !== 76'd0) begin n_fail++; $display("FAIL midrst_data: got %h want 0", {rsp_rdata, mem_be, mem_addr, mem_wdata}); end
    repeat (2) begin
      @(negedge clk);
      n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_no_rsp: got %b want 0", rsp_valid); end
    end
    reset = 1'b1;
    // abort a store while in ACCESS, before its write edge
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b010; req_addr = 32'h28; req_wdata = 32'hDEAD_BEEF;
    @(negedge clk);
    req_valid = 1'b0;
    reset = 1'b0;
    #1;
    n_checks++; if (mem_en !== 1'b0) begin n_fail++; $display("FAIL midrst_store_en: got %b want 0", mem_en); end
    @(negedge clk);
    reset = 1'b1;
    model_txn(1'b1, 3'b010, 32'h24, 32'h0BAD_F00D);
    drive_req(1'b1, 3'b010, 32'h24, 32'h0BAD_F00D, 0);
    n_checks++; if ({r_to, r_lat[3:0], r_en[3:0], r_ma} !== {1'b0, 4'd2, 4'd1, 8'h09}) begin n_fail++; $display("FAIL post_rst_sw: got %h want %h", {r_to, r_lat[3:0], r_en[3:0], r_ma}, {1'b0, 4'd2, 4'd1, 8'h09}); end
    model_txn(1'b0, 3'b010, 32'h28, 32'h0);
    drive_req(1'b0, 3'b010, 32'h28, 32'h0, 0);
    n_checks++; if (r_rdata !== 32'd0) begin n_fail++; $display("FAIL suppressed_write: got %h want 0", r_rdata); end
    model_txn(1'b0, 3'b010, 32'h24, 32'h0);
    drive_req(1'b0, 3'b010, 32'h24, 32'h0, 0);
    n_checks++; if (r_rdata !== 32'h0BAD_F00D) begin n_fail++; $display("FAIL post_rst_lw: got %h want 0badf00d", r_rdata); end
  endtask

  task automatic test_random();
    logic we;
    logic [2:0] f3;
    logic [31:0] addr, wd;
    for (int t = 0; t < 150; t++) begin
      we   = 1'($urandom_range(0, 1));
      f3   = 3'($urandom_range(0, 7));
      addr = ($urandom & 32'hFFFF_FC00) | 32'($urandom_range(0, 63));
      wd   = $urandom;
      model_txn(we, f3, addr, wd);
      drive_req(we, f3, addr, wd, $urandom_range(0, 2));
      n_checks++; if (r_to !== 1'b0) begin n_fail++; $display("FAIL rnd_timeout t=%0d: got %b want 0", t, r_to); end
      n_checks++; if (r_lat !== e_lat) begin n_fail++; $display("FAIL rnd_latency t=%0d we=%b f3=%b a=%h: got %0d want %0d", t, we, f3, addr, r_lat, e_lat); end
      n_checks++; if ({r_err, r_rdata} !== {e_err, e_rdata}) begin n_fail++; $display("FAIL rnd_rsp t=%0d we=%b f3=%b a=%h: got %h want %h", t, we, f3, addr, {r_err, r_rdata}, {e_err, e_rdata}); end
      n_checks++; if (r_en !== e_en) begin n_fail++; $display("FAIL rnd_access_count t=%0d: got %0d want %0d", t, r_en, e_en); end
      if (e_en == 1) begin
        n_checks++; if ({r_mwe, r_be, r_ma} !== {we, e_be, e_ma}) begin n_fail++; $display("FAIL rnd_mem_ctl t=%0d f3=%b a=%h: got %h want %h", t, f3, addr, {r_mwe, r_be, r_ma}, {we, e_be, e_ma}); end
        if (we) begin
          n_checks++; if (r_mw !== e_mw) begin n_fail++; $display("FAIL rnd_mem_wdata t=%0d f3=%b: got %h want %h", t, f3, r_mw, e_mw); end
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_store_word();
    test_byte_store_merge();
    test_load_extend();
    test_misalign();
    test_backpressure();
    test_reset_mid_op();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, %0d failures so far", n_fail);
    $fatal(1);
  end
endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001: Parameter ADDR_W, default 8, word-address width of the attached data RAM (256 words).
REQ-002: clk  input  1  rising-edge clock for all state.
REQ-003: reset  input  1  asynchronous, active-low reset; 0 = reset asserted.
REQ-004: req_valid  input  1  core presents a load/store request.
REQ-005: req_ready  output  1  unit can accept a request this cycle.
REQ-006: req_we  input  1  1 = store, 0 = load.
REQ-007: req_funct3  input  3  RV32I size/sign code (lb/lh/lw/lbu/lhu; sb/sh/sw).
REQ-008: req_addr  input  32  byte address.
REQ-009: req_wdata  input  32  store data, right-aligned.
REQ-010: rsp_valid  output  1  response available.
REQ-011: rsp_ready  input  1  core consumes the response.
REQ-012: rsp_rdata  output  32  formatted load result; 0 for stores.
REQ-013: rsp_err  output  1  request was rejected (see Configuration).
REQ-014: mem_en  output  1  RAM access strobe.
REQ-015: mem_we  output  1  RAM write enable.
REQ-016: mem_be  output  4  RAM byte-lane enables; bit i = byte lane i.
REQ-017: mem_addr  output  ADDR_W  RAM word address = req_addr[ADDR_W+1:2]; upper bits ignored (wrap).
REQ-018: mem_wdata  output  32  lane-replicated store data.
REQ-019: mem_rdata  input  32  RAM read data, valid one cycle after the mem_en read cycle.

Function
REQ-020: FSM states SHALL be IDLE, ACCESS, LOAD, RESP; one request in flight at a time.
REQ-021: req_ready SHALL be 1 only in IDLE; req_valid & req_ready latches we/funct3/addr/wdata and moves to ACCESS.
REQ-022: ACCESS SHALL drive mem_en=1 for exactly one cycle, with mem_we=req_we and mem_be/mem_addr/mem_wdata from the latched request.
REQ-023: Store path SHALL be ACCESS -> RESP; rsp_valid first high 2 cycles after the accept edge.
REQ-024: Load path SHALL be ACCESS -> LOAD -> RESP; LOAD registers formatted mem_rdata into rsp_rdata; rsp_valid first high 3 cycles after the accept edge.
REQ-025: Store lanes SHALL be: sb: be=0001<<addr[1:0], wdata={4{byte}}; sh: be=0011<<(2*addr[1]), wdata={2{half}}; sw: be=1111, wdata as given.
REQ-026: Loads SHALL drive be=1111 and select the byte at addr[1:0] or the half at addr[1]; lb/lh sign-extend, lbu/lhu zero-extend, lw passes 32 bits.
REQ-027: RESP SHALL hold rsp_valid, rsp_rdata and rsp_err stable until rsp_ready=1, then return to IDLE; req_ready is not asserted in the same cycle.
REQ-028: Outside ACCESS, mem_en and mem_we SHALL be 0.
REQ-029: req_valid while not ready SHALL be ignored; the core holds the request.

Reset
REQ-030: reset=0 SHALL immediately force IDLE, with rsp_valid=0, rsp_rdata=0, rsp_err=0, mem_en=0, mem_we=0, mem_be=0, mem_addr=0, mem_wdata=0, and req_ready=0 while reset is held.
REQ-031: Reset asserted mid-operation SHALL abort the request with no response; a write is suppressed unless its ACCESS edge has already occurred.

Configuration
REQ-032: Macro LSU_MISALIGN_CHECK_EN defined: a misaligned half/word or an illegal funct3 (load 011/110/111, store 011-111) skips ACCESS and goes IDLE -> RESP with rsp_err=1 and rsp_rdata=0; no RAM access occurs.
REQ-033: Macro undefined: rsp_err is tied 0; sh/lh ignore addr[0]; sw/lw ignore addr[1:0]; illegal funct3 is treated as word size.

Verification
REQ-034: sw addr 0x64 wdata 0x00000019 -> one mem_en cycle with we=1, be=1111, mem_addr=0x19; rsp_valid 2 cycles after accept, rsp_rdata=0.
REQ-035: sb addr 0x03 wdata 0x000000AB, then lw addr 0x00 over a RAM word 0x11223344 -> be=1000, wdata=0xABABABAB; lw returns 0xAB223344 3 cycles after accept.
REQ-036: lb/lbu/lh/lhu at addr 0x02 over word 0x80F0_0000 -> 0xFFFFFFF0 / 0x000000F0 / 0xFFFF80F0 / 0x000080F0.
REQ-037: rsp_ready held 0 for 5 cycles in RESP -> rsp_valid and rsp_rdata stay stable, req_ready stays 0; a second req_valid is accepted only after return to IDLE.
REQ-038: With LSU_MISALIGN_CHECK_EN defined, lw addr 0x62 -> no mem_en, rsp_err=1 and rsp_rdata=0 one cycle after accept; without the macro, the same request reads word 0x18 with rsp_err=0.
REQ-039: Assert reset during the LOAD state -> outputs zero at once, no rsp_valid; after release a new sw completes normally.
